iter_shift: RTL and testbench

ITER_SHIFT -- requirements
Module: iter_shift

---
 rtl/iter_shift_if.sv | 13 +
 rtl/iter_shift.sv | 84 ++++++++
 tb/tb_iter_shift.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/iter_shift_if.sv
// Request/response bundle for the iterative shifter: operands in, busy/done/result out.
interface iter_shift_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rt;
  logic [4:0]  sa;
  logic        busy;
  logic        done;
  logic [31:0] res;

  modport master (output start, op, rt, sa, input busy, done, res);
  modport slave  (input start, op, rt, sa, output busy, done, res);
endinterface

// File: rtl/iter_shift.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROR performed one bit per clock.
// Takes sa cycles in SHIFT, followed by a one-cycle done pulse.
module iter_shift (
  input  logic        clk,
  input  logic        reset,
  iter_shift_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 5;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [SW-1:0] cnt;
  logic [1:0]    op_q;
  logic [DW-1:0] res_q;
  logic [DW-1:0] step_c;
  logic          busy_q;
  logic          done_q;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.res  = res_q;

  // Single-bit step of the latched operation
  always_comb begin
    step_c = res_q;
    case (op_q)
      2'b00:   step_c = {res_q[DW-2:0], 1'b0};
      2'b01:   step_c = {1'b0, res_q[DW-1:1]};
      2'b10:   step_c = {res_q[DW-1], res_q[DW-1:1]};
      default: step_c = {res_q[0], res_q[DW-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      res_q  <= '0;
      cnt    <= '0;
      op_q   <= 2'b00;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        // DONE accepts a new request exactly like IDLE, allowing back-to-back ops
        IDLE, DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.start) begin
            res_q <= bus.rt;
            cnt   <= bus.sa;
            op_q  <= bus.op;
            if (bus.sa != '0) begin
              state  <= SHIFT;
              busy_q <= 1'b1;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            res_q <= step_c;
            cnt   <= cnt - SW'(1);
          end
          // cnt==0 is unreachable here; treating it as finished keeps the FSM from sticking
          if (cnt == SW'(1) || cnt == '0) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_iter_shift.sv
// Scoreboard bench for iter_shift: driver queues expected results, monitor checks on done.
module tb_iter_shift;
  logic clk;
  logic reset;

  iter_shift_if bus ();

  iter_shift dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          sa;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   busy_cnt = 0;

  // Reference: full-width shift computed directly from the operation definition
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] rt,
                                            input logic [4:0] sa);
    logic [63:0] dbl;
    case (op)
      2'b00:   return rt << sa;
      2'b01:   return rt >> sa;
      2'b10:   return 32'($signed(rt) >>> sa);
      default: begin
        dbl = {rt, rt} >> sa;
        return dbl[31:0];
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: res %h with no request outstanding", bus.res);
        end else begin
          e = sb.pop_front();
          check("res", bus.res, e.res);
          check("busy_cycles", 32'(busy_cnt), 32'(e.sa));
          check("busy_with_done", 32'(bus.busy), 32'd0);
        end
        busy_cnt = 0;
      end
    end
  end

  // Present a request; align=1 waits for a fresh negedge first, else drives immediately
  task automatic issue(input logic [1:0] op, input logic [31:0] rt, input logic [4:0] sa,
                       input logic [31:0] exp_res, input bit align);
    exp_t e;
    if (align) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rt    = rt;
    bus.sa    = sa;
    e.res = exp_res;
    e.sa  = int'(sa);
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.rt    = $urandom;
    bus.sa    = 5'($urandom);
    bus.op    = 2'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL timeout: done not seen within 40 cycles, got 0, expected 1");
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] rt, input logic [4:0] sa,
                     input logic [31:0] exp_res);
    issue(op, rt, sa, exp_res, 1'b1);
    wait_done();
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] rrt;
    logic [4:0]  rsa;

    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.rt    = '0;
    bus.sa    = '0;
    reset     = 1'b0;
    #3;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_res", bus.res, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Directed cases
    run(2'b00, 32'h0000_0001, 5'd4, 32'h0000_0010);
    run(2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    run(2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);
    run(2'b11, 32'h1234_5678, 5'd8, 32'h7812_3456);
    run(2'b00, 32'h1234_5678, 5'd0, 32'h1234_5678);
    @(negedge clk);
    check("res_hold_idle", bus.res, 32'h1234_5678);

    // Inputs toggled during SHIFT must be ignored
    issue(2'b01, 32'hF000_0000, 5'd4, 32'h0F00_0000, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.rt    = '0;
    bus.sa    = 5'd1;
    bus.op    = 2'b00;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);

    // Back-to-back: new start during the DONE cycle
    run(2'b00, 32'h0000_0003, 5'd2, 32'h0000_000C);
    issue(2'b00, 32'h0000_00FF, 5'd1, 32'h0000_01FE, 1'b0);
    wait_done();

    // Asynchronous reset on the second SHIFT cycle
    issue(2'b00, 32'h0000_0001, 5'd10, 32'h0000_0400, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_res", bus.res, 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    run(2'b11, 32'h0000_0001, 5'd1, 32'h8000_0000);

    // Random operations, some issued back-to-back
    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom);
      rrt = $urandom;
      rsa = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      issue(rop, rrt, rsa, ref_shift(rop, rrt, rsa), ($urandom_range(0, 2) != 0));
      wait_done();
    end

    repeat (4) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL outstanding: %0d results never reported, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
